// File: rtl/seg7_disp_sched.sv
// Four-digit multiplexed 7-segment display driver with a two-requester round-robin write port.
// Optional per-digit blinking is compiled in with macro SEG7_BLINK_EN.
module seg7_disp_sched #(
  parameter int unsigned SCAN_DIV  = 16000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_addr,
  input  logic [4:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_addr,
  input  logic [4:0] req1_data,
  output logic       req1_ready,
  input  logic       blank,
`ifdef SEG7_BLINK_EN
  input  logic [3:0] blink_mask,
`endif
  output logic [3:0] AN,
  output logic [7:0] SEG,
  output logic       frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [4:0]    disp_q [4];
  logic          pref1_q;
  logic [3:0]    an_q;
  logic [7:0]    seg_q;
  logic          ftick_q;
  logic          slot_wrap;
  logic          grant0, grant1;
  logic          dim;

  assign slot_wrap = (presc_q == PW'(SCAN_DIV - 1));

  // Round-robin: pref1_q set means requester 1 wins the next contention.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~pref1_q);
    grant1     = req1_valid & (~req0_valid | pref1_q);
    req0_ready = grant0 & ~rst;
    req1_ready = grant1 & ~rst;
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    s = 7'b1111111;
    case (code)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (slot_wrap) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign dim = ~blink_on_q & blink_mask[idx_q];
`else
  assign dim = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      pref1_q <= 1'b0;
      an_q    <= 4'b1110;
      seg_q   <= 8'hFF;
      ftick_q <= 1'b0;
      for (int i = 0; i < 4; i++) disp_q[i] <= 5'h0F;
    end else begin
      presc_q <= slot_wrap ? '0 : presc_q + 1'b1;
      if (slot_wrap) idx_q <= idx_q + 2'd1;
      ftick_q <= slot_wrap & (idx_q == 2'd3);
      if (req0_ready) begin
        disp_q[req0_addr] <= req0_data;
        pref1_q           <= 1'b1;
      end else if (req1_ready) begin
        disp_q[req1_addr] <= req1_data;
        pref1_q           <= 1'b0;
      end
      // Both outputs come from the same pre-edge state, so AN and SEG move together.
      an_q  <= blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_q <= (blank | dim) ? 8'hFF : {seg_decode(disp_q[idx_q][3:0]), ~disp_q[idx_q][4]};
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_tick = ftick_q;

endmodule
